// File: rtl/lcd_pack_pkg.sv
// lcd_pack_pkg: shared state encoding, stream byte lanes and pad constants for the RGB packer
package lcd_pack_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    // position of each component inside the 6-byte beat stream (byte 0 goes out first)
    localparam int LANE_R0 = 0;
    localparam int LANE_G0 = 1;
    localparam int LANE_B0 = 2;
    localparam int LANE_R1 = 3;
    localparam int LANE_G1 = 4;
    localparam int LANE_B1 = 5;

    localparam logic [7:0] PAD_BYTE = 8'h00;

    // FIFO entry: {eof, sof, data[31:0]}
    localparam int FIFO_W = 34;

endpackage

// File: rtl/lcd_pack_fifo.sv
// lcd_pack_fifo: 2-write/1-read synchronous FIFO with occupancy-based free count
module lcd_pack_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 34
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push0,
    input  logic                       push1,
    input  logic [DW-1:0]              din0,
    input  logic [DW-1:0]              din1,
    input  logic                       pop,
    output logic [DW-1:0]              dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     free_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop_ok;

    assign valid    = count != '0;
    assign pop_ok   = pop && valid;
    assign dout     = valid ? mem[rd_ptr] : '0;
    assign free_cnt = (AW+1)'(DEPTH) - count;

    // storage writes; push1 always lands in the slot after push0
    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr] <= din0;
        if (push1) mem[wr_ptr + AW'(1)] <= din1;
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            count  <= count + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/lcd_rgb_packer.sv
// lcd_rgb_packer: packs 2-pixel RGB888 beats into a byte-continuous 32-bit word stream
module lcd_rgb_packer import lcd_pack_pkg::*; #(
    parameter int IMG_PIX_W  = 8,
    parameter int W_SIZE     = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [W_SIZE-1:0]    cfg_width,
    input  logic [W_SIZE-1:0]    cfg_height,
    input  logic                 cfg_start,
    input  logic                 in_valid,
    input  logic [IMG_PIX_W-1:0] in_r0,
    input  logic [IMG_PIX_W-1:0] in_g0,
    input  logic [IMG_PIX_W-1:0] in_b0,
    input  logic [IMG_PIX_W-1:0] in_r1,
    input  logic [IMG_PIX_W-1:0] in_g1,
    input  logic [IMG_PIX_W-1:0] in_b1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 frame_done,
    output logic                 overflow,
    output logic                 busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 2 * W_SIZE;

    state_t              state;
    logic [CW-1:0]       total_beats, beat_cnt, beat_nxt;
    logic                phase, sof_pending, pad_done, eof_pushed;
    logic [15:0]         residue;
    logic                stg_push0, stg_push1;
    logic [FIFO_W-1:0]   stg_d0, stg_d1, head;
    logic [AW:0]         free_cnt;
    logic [AW+1:0]       avail;
    logic [47:0]         stream;
    logic [31:0]         w0;
    logic [W_SIZE-1:0]   eff_w;
    logic                pop, beat, fits, acc, last_beat, pad_go, start_ok, flush_exit;

    assign eff_w     = cfg_width & ~W_SIZE'(1);
    assign start_ok  = state == IDLE && cfg_start && eff_w != '0 && cfg_height != '0;
    assign pop       = out_valid && out_ready;
    // staged words land in the FIFO next edge, so they already count against free space
    assign avail     = (AW+2)'(free_cnt) + (AW+2)'(pop) - (AW+2)'(stg_push0) - (AW+2)'(stg_push1);
    assign beat      = state == RUN && in_valid;
    assign fits      = avail >= (phase ? (AW+2)'(2) : (AW+2)'(1));
    assign acc       = beat && fits;
    assign beat_nxt  = beat_cnt + CW'(1);
    assign last_beat = beat_nxt == total_beats;
    assign pad_go    = state == FLUSH && phase && !pad_done && avail != '0;
    // without an eof word in flight (last beat dropped on an even boundary) the frame ends once drained
    assign flush_exit = state == FLUSH && (eof_pushed ? (pop && head[33]) : (!phase && !out_valid && !stg_push0));
    assign w0        = phase ? {stream[15:0], residue} : stream[31:0];
    assign busy      = state != IDLE;
    assign out_data  = head[31:0];
    assign out_sof   = head[32];
    assign out_eof   = head[33];

    // lay the beat out as a 6-byte stream, first byte in the low lane
    always_comb begin
        stream = '0;
        stream[8*LANE_R0 +: 8] = in_r0;
        stream[8*LANE_G0 +: 8] = in_g0;
        stream[8*LANE_B0 +: 8] = in_b0;
        stream[8*LANE_R1 +: 8] = in_r1;
        stream[8*LANE_G1 +: 8] = in_g1;
        stream[8*LANE_B1 +: 8] = in_b1;
    end

    // frame FSM, start latch, packer state and the one-deep push stage
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= IDLE;
            total_beats <= '0;
            beat_cnt    <= '0;
            phase       <= 1'b0;
            residue     <= '0;
            sof_pending <= 1'b0;
            pad_done    <= 1'b0;
            eof_pushed  <= 1'b0;
            overflow    <= 1'b0;
            frame_done  <= 1'b0;
            stg_push0   <= 1'b0;
            stg_push1   <= 1'b0;
            stg_d0      <= '0;
            stg_d1      <= '0;
        end else begin
            frame_done <= 1'b0;
            stg_push0  <= acc || pad_go;
            stg_push1  <= acc && phase;
            stg_d0     <= pad_go ? {1'b1, sof_pending, PAD_BYTE, PAD_BYTE, residue} : {1'b0, sof_pending, w0};
            stg_d1     <= {last_beat, 1'b0, stream[47:16]};
            if (start_ok) begin
                state       <= RUN;
                total_beats <= CW'(eff_w[W_SIZE-1:1]) * CW'(cfg_height);
                beat_cnt    <= '0;
                phase       <= 1'b0;
                residue     <= '0;
                overflow    <= 1'b0;
                sof_pending <= 1'b1;
                pad_done    <= 1'b0;
                eof_pushed  <= 1'b0;
            end
            if (beat) begin
                beat_cnt <= beat_nxt;
                if (fits) begin
                    phase       <= !phase;
                    sof_pending <= 1'b0;
                    if (!phase) residue <= stream[47:32];
                end else begin
                    overflow <= 1'b1;
                end
                if (last_beat) state <= FLUSH;
            end
            if (pad_go) begin
                pad_done    <= 1'b1;
                sof_pending <= 1'b0;
            end
            if ((acc && phase && last_beat) || pad_go) eof_pushed <= 1'b1;
            if (flush_exit) begin
                state      <= IDLE;
                frame_done <= 1'b1;
            end
        end
    end

    lcd_pack_fifo #(.DEPTH(FIFO_DEPTH), .DW(FIFO_W)) u_fifo (
        .clk      (HCLK),
        .rst      (HRESET),
        .push0    (stg_push0),
        .push1    (stg_push1),
        .din0     (stg_d0),
        .din1     (stg_d1),
        .pop      (pop),
        .dout     (head),
        .valid    (out_valid),
        .free_cnt (free_cnt)
    );

endmodule

// File: tb/tb_lcd_rgb_packer.sv
// tb_lcd_rgb_packer: directed-vector bench for the RGB word packer
module tb_lcd_rgb_packer;

    logic        HCLK, HRESET;
    logic [11:0] cfg_width, cfg_height;
    logic        cfg_start, in_valid, out_ready;
    logic [7:0]  in_r0, in_g0, in_b0, in_r1, in_g1, in_b1;
    logic        out_valid, out_sof, out_eof, frame_done, overflow, busy;
    logic [31:0] out_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int eof_cyc = -100;
    int fd_cyc = -200;
    logic [33:0] got_q[$];
    logic [33:0] exp_q[$];

    lcd_rgb_packer dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_start(cfg_start),
        .in_valid(in_valid),
        .in_r0(in_r0), .in_g0(in_g0), .in_b0(in_b0),
        .in_r1(in_r1), .in_g1(in_g1), .in_b1(in_b1),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eof(out_eof),
        .frame_done(frame_done), .overflow(overflow), .busy(busy)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // capture every handshaken word mid-cycle, when inputs and outputs are settled
    always @(negedge HCLK) begin
        cyc++;
        if (out_valid && out_ready) begin
            got_q.push_back({out_eof, out_sof, out_data});
            if (out_eof) eof_cyc = cyc;
        end
        if (frame_done) fd_cyc = cyc;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic start(input int w, input int h);
        cfg_width = 12'(w);
        cfg_height = 12'(h);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // beat k carries stream bytes 6k+1 .. 6k+6
    task automatic send_beat(input int k);
        in_valid = 1'b1;
        in_r0 = 8'(6*k+1); in_g0 = 8'(6*k+2); in_b0 = 8'(6*k+3);
        in_r1 = 8'(6*k+4); in_g1 = 8'(6*k+5); in_b1 = 8'(6*k+6);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic exp_seq(input int n, input bit eof_last);
        for (int j = 0; j < n; j++)
            exp_q.push_back({eof_last && j == n-1, j == 0,
                             8'(4*j+4), 8'(4*j+3), 8'(4*j+2), 8'(4*j+1)});
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!frame_done && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(frame_done), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        tick();
    endtask

    task automatic compare_frame(input string tag);
        chk({tag, "_cnt"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        HRESET = 1'b1; cfg_width = '0; cfg_height = '0; cfg_start = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        in_r0 = '0; in_g0 = '0; in_b0 = '0; in_r1 = '0; in_g1 = '0; in_b1 = '0;
        repeat (2) tick();
        chk("reset_outs", {26'd0, out_valid, out_sof, out_eof, frame_done, overflow, busy, out_data}, 64'd0);
        HRESET = 1'b0;
        tick();

        // basic 4x2 frame with latency and done timing
        start(4, 2);
        chk("t1_busy", 64'(busy), 64'd1);
        send_beat(0);
        chk("t1_lat0", 64'(out_valid), 64'd0);
        tick();
        chk("t1_lat1", {out_valid, out_sof, out_data}, {30'd0, 2'b11, 32'h04030201});
        for (int k = 1; k < 4; k++) send_beat(k);
        wait_done("t1");
        chk("t1_fd_after_eof", 64'(fd_cyc - eof_cyc), 64'd1);
        exp_seq(6, 1'b1);
        compare_frame("t1");

        // pad flush, 2x1
        start(2, 1);
        send_beat(0);
        wait_done("t2");
        exp_q.push_back({2'b01, 32'h04030201});
        exp_q.push_back({2'b10, 32'h00000605});
        compare_frame("t2");

        // width with bit0 clear is zero: start ignored
        start(1, 3);
        chk("zero_w_busy", 64'(busy), 64'd0);

        // ignored IDLE beats, odd width, start during RUN
        send_beat(20);
        send_beat(21);
        repeat (3) tick();
        chk("idle_beats", 64'(got_q.size()), 64'd0);
        start(5, 2);
        send_beat(0);
        start(2, 1);
        cfg_width = 12'd5;
        cfg_height = 12'd2;
        for (int k = 1; k < 4; k++) send_beat(k);
        wait_done("t4");
        exp_seq(6, 1'b1);
        compare_frame("t4");

        // backpressure overflow: 40x1 = 20 beats, consumer stalled
        out_ready = 1'b0;
        start(40, 1);
        for (int k = 0; k < 20; k++) begin
            send_beat(k);
            if (k == 10) chk("ovf_b11", 64'(overflow), 64'd0);
            if (k == 11) chk("ovf_b12", 64'(overflow), 64'd1);
        end
        send_beat(30);
        send_beat(31);
        repeat (4) tick();
        chk("t3_hold_a", {out_valid, out_sof, out_eof, out_data}, {29'd0, 3'b110, 32'h04030201});
        tick();
        chk("t3_hold_b", {out_valid, out_sof, out_eof, out_data}, {29'd0, 3'b110, 32'h04030201});
        chk("t3_busy", 64'(busy), 64'd1);
        out_ready = 1'b1;
        wait_done("t3");
        chk("t3_ovf_sticky", 64'(overflow), 64'd1);
        exp_seq(16, 1'b0);
        exp_q.push_back({2'b10, 32'h00004241});
        compare_frame("t3");
        start(4, 2);
        chk("ovf_clr", 64'(overflow), 64'd0);
        for (int k = 0; k < 4; k++) send_beat(k);
        wait_done("t5");
        exp_seq(6, 1'b1);
        compare_frame("t5");

        // reset mid-frame of a 768x512 frame, then a clean restart
        out_ready = 1'b0;
        start(768, 512);
        for (int k = 0; k < 3; k++) send_beat(k);
        tick();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk("rst_outs", {26'd0, out_valid, out_sof, out_eof, frame_done, overflow, busy, out_data}, 64'd0);
        out_ready = 1'b1;
        got_q.delete();
        start(4, 2);
        for (int k = 0; k < 4; k++) send_beat(k);
        wait_done("t6");
        exp_seq(6, 1'b1);
        compare_frame("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
